// File: rtl/mem_responder_pkg.sv
// ----------------------------------------------------------------------------
// mem_pkg
// Purpose : Shared definitions for the memory responder slice: FSM state
//           encoding, request operation encoding and default bus widths.
// Ports   : none (package)
// ----------------------------------------------------------------------------
package mem_pkg;

    localparam int DEF_ADDR_W = 9;
    localparam int DEF_DATA_W = 32;

    // Responder sequencing: capture in IDLE, count wait states in WAIT,
    // hold mem_done in RESP until the requester lets go.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

endpackage

// File: rtl/mem_responder_if.sv
// ----------------------------------------------------------------------------
// mem_responder_if
// Purpose : MAR/MDR memory bus between the datapath/control unit (master) and
//           the memory responder (slave).
// Signals : read, write  - level requests, held until mem_done
//           mar          - 32-bit address from MAR
//           mdr          - write data from MDR
//           mdatain      - read data back to the datapath MDR input mux
//           mem_done     - request complete, high until request deasserted
//           mem_err      - one-cycle pulse when read and write were both high
// ----------------------------------------------------------------------------
interface mem_responder_if
    import mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);

    logic              read;
    logic              write;
    logic [31:0]       mar;
    logic [DATA_W-1:0] mdr;
    logic [DATA_W-1:0] mdatain;
    logic              mem_done;
    logic              mem_err;

    modport master (
        output read, write, mar, mdr,
        input  mdatain, mem_done, mem_err
    );

    modport slave (
        input  read, write, mar, mdr,
        output mdatain, mem_done, mem_err
    );

endinterface

// File: rtl/mem_responder_ram.sv
// ----------------------------------------------------------------------------
// sync_ram_core
// Purpose : Single-port word RAM with synchronous read and write. Only one
//           operation happens per enabled edge, so read/write ordering on the
//           same address never arises. The read register is the only state
//           that is reset; the array keeps its contents across reset.
// Ports   : clk      - rising-edge clock
//           clear    - asynchronous active-low reset of the read register
//           i_en     - perform an access on this edge
//           i_we     - 1 = write, 0 = read (qualified by i_en)
//           i_addr   - word address
//           i_wdata  - write data
//           o_rdata  - registered read data, held until the next read
// ----------------------------------------------------------------------------
module sync_ram_core
    import mem_pkg::*;
#(
    parameter int    ADDR_W    = DEF_ADDR_W,
    parameter int    DATA_W    = DEF_DATA_W,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    // Power-on image: all zeros.
    initial begin
        for (int i = 0; i < 2**ADDR_W; i++) begin
            r_mem[i] = '0;
        end
    end

    // Array writes are deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (i_en && i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Read data only moves on a read access, so writes leave it untouched.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_rdata <= '0;
        end else if (i_en && !i_we) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// ----------------------------------------------------------------------------
// mem_responder
// Purpose : Memory-side responder for the datapath MAR/MDR bus. Captures a
//           level read/write request in IDLE, waits WAIT_STATES cycles, then
//           performs the access on the internal RAM and raises mem_done until
//           the request is dropped (4-phase handshake).
// Ports   : clk    - rising-edge clock
//           clear  - asynchronous active-low reset
//           bus    - mem_responder_if slave (read, write, mar, mdr in;
//                    mdatain, mem_done, mem_err out)
// ----------------------------------------------------------------------------
module mem_responder
    import mem_pkg::*;
#(
    parameter int    ADDR_W      = DEF_ADDR_W,
    parameter int    DATA_W      = DEF_DATA_W,
    parameter int    WAIT_STATES = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic           clk,
    input  logic           clear,
    mem_responder_if.slave bus
);

    state_t            r_state;
    logic [3:0]        r_count;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    op_t               r_op;
    logic              r_memDone;
    logic              r_memErr;

    logic              w_request;
    logic              w_access;
    logic [DATA_W-1:0] w_rdata;
    logic              w_unusedMarBits;

    assign w_request = bus.read | bus.write;

    // Address bits above ADDR_W alias onto the same words.
    assign w_unusedMarBits = ^bus.mar[31:ADDR_W];

    // The access edge is the last WAIT edge; with zero wait states the count
    // is already zero on the first WAIT edge, giving one cycle of latency.
    assign w_access = (r_state == WAIT) && (r_count == 4'd0);

    // Request sequencer. Address, data and op are frozen at capture so later
    // MAR/MDR activity cannot disturb an in-flight access. A simultaneous
    // read and write is resolved as a write and flagged for one cycle.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_state   <= IDLE;
            r_count   <= 4'd0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_op      <= OP_RD;
            r_memDone <= 1'b0;
            r_memErr  <= 1'b0;
        end else begin
            r_memErr <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_request) begin
                        r_addr   <= bus.mar[ADDR_W-1:0];
                        r_wdata  <= bus.mdr;
                        r_op     <= bus.write ? OP_WR : OP_RD;
                        r_memErr <= bus.read & bus.write;
                        r_count  <= 4'(WAIT_STATES);
                        r_state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_count == 4'd0) begin
                        r_memDone <= 1'b1;
                        r_state   <= RESP;
                    end else begin
                        r_count <= r_count - 4'd1;
                    end
                end
                RESP: begin
                    if (!w_request) begin
                        r_memDone <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_memDone <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    sync_ram_core #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk     (clk),
        .clear   (clear),
        .i_en    (w_access),
        .i_we    (r_op == OP_WR),
        .i_addr  (r_addr),
        .i_wdata (r_wdata),
        .o_rdata (w_rdata)
    );

    assign bus.mdatain  = w_rdata;
    assign bus.mem_done = r_memDone;
    assign bus.mem_err  = r_memErr;

endmodule

// File: tb/tb_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_mem_responder
// Purpose : Self-checking bench for mem_responder. Three instances with
//           WAIT_STATES = 0, 2 and 15 share one set of request drivers; the
//           WAIT_STATES = 2 instance carries the functional traffic.
// ----------------------------------------------------------------------------
module tb_mem_responder;

    logic        clk;
    logic        clear;
    logic        read;
    logic        write;
    logic [31:0] mar;
    logic [31:0] mdr;

    int compared;
    int mismatched;

    mem_responder_if #(.DATA_W(32)) bus0  ();
    mem_responder_if #(.DATA_W(32)) bus2  ();
    mem_responder_if #(.DATA_W(32)) bus15 ();

    assign bus0.read   = read;
    assign bus0.write  = write;
    assign bus0.mar    = mar;
    assign bus0.mdr    = mdr;
    assign bus2.read   = read;
    assign bus2.write  = write;
    assign bus2.mar    = mar;
    assign bus2.mdr    = mdr;
    assign bus15.read  = read;
    assign bus15.write = write;
    assign bus15.mar   = mar;
    assign bus15.mdr   = mdr;

    mem_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_STATES(0), .INIT_FILE(""))
        dut0 (.clk(clk), .clear(clear), .bus(bus0));
    mem_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_STATES(2), .INIT_FILE(""))
        dut2 (.clk(clk), .clear(clear), .bus(bus2));
    mem_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_STATES(15), .INIT_FILE(""))
        dut15 (.clk(clk), .clear(clear), .bus(bus15));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] expData;
        int          expLat;
        int          expErrCycles;
    } vec_t;

    vec_t vecs [9];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // One full 4-phase transaction on the WAIT_STATES=2 instance. MAR/MDR are
    // scrambled right after capture to prove the captured copies are used.
    task automatic applyStimulus(input vec_t v, output int lat, output int errCycles,
                                 output logic [31:0] dataAtDone, output logic doneAfterDrop,
                                 output logic timedOut);
        @(negedge clk);
        read  = v.rd;
        write = v.wr;
        mar   = v.addr;
        mdr   = v.data;
        @(posedge clk);
        #1;
        errCycles = bus2.mem_err ? 1 : 0;
        lat       = 0;
        timedOut  = 1'b1;
        @(negedge clk);
        mar = ~v.addr;
        mdr = ~v.data;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus2.mem_err) errCycles++;
            if (bus2.mem_done) begin
                timedOut = 1'b0;
                break;
            end
        end
        dataAtDone = bus2.mdatain;
        @(negedge clk);
        read  = 1'b0;
        write = 1'b0;
        @(posedge clk);
        #1;
        doneAfterDrop = bus2.mem_done;
    endtask

    initial begin
        int          lat;
        int          errCycles;
        logic [31:0] dataAtDone;
        logic        doneAfterDrop;
        logic        timedOut;
        int          first0;
        int          first2;
        int          first15;
        logic        stayedLow;
        vec_t        v;

        compared   = 0;
        mismatched = 0;

        //              rd    wr    addr          data          expData       lat err
        vecs[0] = '{1'b0, 1'b1, 32'h0000_0085, 32'h0000_0002, 32'h0000_0000, 3, 0};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0085, 32'h0000_0000, 32'h0000_0002, 3, 0};
        vecs[2] = '{1'b0, 1'b1, 32'h0000_0205, 32'h0000_0011, 32'h0000_0002, 3, 0};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_0005, 32'h0000_0000, 32'h0000_0011, 3, 0};
        vecs[4] = '{1'b1, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 32'h0000_0011, 3, 1};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 32'hDEAD_BEEF, 3, 0};
        vecs[6] = '{1'b0, 1'b1, 32'h0000_01FF, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 3, 0};
        vecs[7] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 32'hA5A5_A5A5, 3, 0};
        vecs[8] = '{1'b1, 1'b0, 32'h0000_0085, 32'h0000_0000, 32'h0000_0002, 3, 0};

        // Reset state.
        clear = 1'b0;
        read  = 1'b0;
        write = 1'b0;
        mar   = '0;
        mdr   = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_mdatain", bus2.mdatain, 32'h0);
        checkOutput("reset_mem_done", {31'b0, bus2.mem_done}, 32'h0);
        checkOutput("reset_mem_err", {31'b0, bus2.mem_err}, 32'h0);
        @(negedge clk);
        clear = 1'b1;

        // Latency sweep: one read seen by all three instances at the same edge.
        @(negedge clk);
        read = 1'b1;
        mar  = 32'h0;
        @(posedge clk);
        first0  = -1;
        first2  = -1;
        first15 = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (first0  < 0 && bus0.mem_done)  first0  = c;
            if (first2  < 0 && bus2.mem_done)  first2  = c;
            if (first15 < 0 && bus15.mem_done) first15 = c;
        end
        checkOutput("latency_ws0", 32'(first0), 32'd1);
        checkOutput("latency_ws2", 32'(first2), 32'd3);
        checkOutput("latency_ws15", 32'(first15), 32'd16);
        @(negedge clk);
        read = 1'b0;
        repeat (2) @(posedge clk);

        // Table-driven transactions.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i], lat, errCycles, dataAtDone, doneAfterDrop, timedOut);
            checkOutput($sformatf("vec%0d_timeout", i), {31'b0, timedOut}, 32'h0);
            checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].expLat));
            checkOutput($sformatf("vec%0d_mdatain", i), dataAtDone, vecs[i].expData);
            checkOutput($sformatf("vec%0d_err_cycles", i), 32'(errCycles),
                        32'(vecs[i].expErrCycles));
            checkOutput($sformatf("vec%0d_done_drop", i), {31'b0, doneAfterDrop}, 32'h0);
        end

        // Hold: read stays high 5 cycles past mem_done, no re-trigger after drop.
        @(negedge clk);
        read = 1'b1;
        mar  = 32'h0000_0005;
        @(posedge clk);
        timedOut = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (bus2.mem_done) begin
                timedOut = 1'b0;
                break;
            end
        end
        checkOutput("hold_timeout", {31'b0, timedOut}, 32'h0);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("hold_done_c%0d", c), {31'b0, bus2.mem_done}, 32'h1);
        end
        checkOutput("hold_mdatain", bus2.mdatain, 32'h0000_0011);
        @(negedge clk);
        read = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("hold_done_drop", {31'b0, bus2.mem_done}, 32'h0);
        stayedLow = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (bus2.mem_done) stayedLow = 1'b0;
        end
        checkOutput("hold_no_retrigger", {31'b0, stayedLow}, 32'h1);

        // Reset mid-WAIT aborts the pending write.
        v = '{1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, 32'h0000_0011, 3, 0};
        applyStimulus(v, lat, errCycles, dataAtDone, doneAfterDrop, timedOut);
        checkOutput("pre_reset_write_latency", 32'(lat), 32'd3);
        @(negedge clk);
        write = 1'b1;
        mar   = 32'h0000_0010;
        mdr   = 32'hBAD0_BAD0;
        @(posedge clk);
        @(posedge clk);
        #2;
        clear = 1'b0;
        #1;
        checkOutput("abort_mdatain", bus2.mdatain, 32'h0);
        checkOutput("abort_mem_done", {31'b0, bus2.mem_done}, 32'h0);
        checkOutput("abort_mem_err", {31'b0, bus2.mem_err}, 32'h0);
        @(negedge clk);
        write = 1'b0;
        @(negedge clk);
        clear = 1'b1;
        v = '{1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, 3, 0};
        applyStimulus(v, lat, errCycles, dataAtDone, doneAfterDrop, timedOut);
        checkOutput("abort_timeout", {31'b0, timedOut}, 32'h0);
        checkOutput("abort_old_value", dataAtDone, 32'h1234_5678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
